// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - integer ALU execute stage with in-order CDB result FIFO and RS credit
// Optional feature: define ALU_CDB_BYPASS_EN to offer the EX result to the CDB when the FIFO is empty.
package alu_exec_pkg;
  localparam int ALU_ROB_W = 3;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SRA  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_ops_t;

  typedef struct packed {
    logic [3:0]           operation;
    logic [31:0]          q1_data;
    logic [31:0]          q2_data;
    logic [ALU_ROB_W-1:0] rob_dest;
  } rs_alu_output_t;

  typedef struct packed {
    logic [ALU_ROB_W-1:0] rob_entry;
    logic [31:0]          rd_data;
  } cdb_t;
endpackage

module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int OUT_DEPTH = 2,
  parameter int ROB_W     = alu_exec_pkg::ALU_ROB_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           rs_result_en,
  input  rs_alu_output_t rs_result,
  output logic           unit_ready,
  output logic           cdb_req,
  input  logic           cdb_grant,
  output cdb_t           cdb_out
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  logic             ex_valid;
  rs_alu_output_t   ex_op;
  logic [31:0]      ex_data;
  logic [ROB_W-1:0] ex_tag;
  cdb_t             ex_cdb;

  cdb_t             mem [OUT_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic [PW+1:0]    occ;

  logic fifo_empty;
  logic fifo_full;
  logic byp_offer;
  logic byp_taken;
  logic pop;
  logic push;
  logic ex_hold;

  always_comb begin
    ex_data = '0;
    case (alu_ops_t'(ex_op.operation))
      ALU_ADD:  ex_data = ex_op.q1_data + ex_op.q2_data;
      ALU_SLL:  ex_data = ex_op.q1_data << ex_op.q2_data[4:0];
      ALU_SRA:  ex_data = $signed(ex_op.q1_data) >>> ex_op.q2_data[4:0];
      ALU_SUB:  ex_data = ex_op.q1_data - ex_op.q2_data;
      ALU_XOR:  ex_data = ex_op.q1_data ^ ex_op.q2_data;
      ALU_SRL:  ex_data = ex_op.q1_data >> ex_op.q2_data[4:0];
      ALU_OR:   ex_data = ex_op.q1_data | ex_op.q2_data;
      ALU_AND:  ex_data = ex_op.q1_data & ex_op.q2_data;
      ALU_SLT:  ex_data = {31'd0, $signed(ex_op.q1_data) < $signed(ex_op.q2_data)};
      ALU_SLTU: ex_data = {31'd0, ex_op.q1_data < ex_op.q2_data};
      default:  ex_data = '0;
    endcase
  end

  assign ex_tag = ex_op.rob_dest;
  assign ex_cdb = '{rob_entry: ex_tag, rd_data: ex_data};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (PW+1)'(OUT_DEPTH));

`ifdef ALU_CDB_BYPASS_EN
  assign byp_offer = ex_valid && fifo_empty;
`else
  assign byp_offer = 1'b0;
`endif

  assign cdb_req   = !fifo_empty || byp_offer;
  assign pop       = !fifo_empty && cdb_grant;
  assign byp_taken = byp_offer && cdb_grant;
  // A full FIFO can still accept when its head leaves in the same cycle.
  assign push      = ex_valid && !byp_taken && (!fifo_full || pop);
  assign ex_hold   = ex_valid && !byp_taken && !push;

  always_comb begin
    cdb_out = '0;
    if (!fifo_empty) begin
      cdb_out = mem[rd_ptr];
    end else if (byp_offer) begin
      cdb_out = ex_cdb;
    end
  end

  // The current issue pulse is counted so the RS's one-cycle issue delay never overruns.
  assign occ = {1'b0, count} + (PW+2)'(ex_valid) + (PW+2)'(rs_result_en);
  assign unit_ready = (occ < (PW+2)'(OUT_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_op    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (!ex_hold) begin
        ex_valid <= rs_result_en;
        if (rs_result_en) begin
          ex_op <= rs_result;
        end
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: cdb_out is gated by the registered count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= ex_cdb;
    end
  end

`ifndef SYNTHESIS
  a_no_issue_drop: assert property (@(posedge clk) disable iff (!rst_n)
    !(rs_result_en && ex_hold && !flush));
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard bench for alu_exec_unit against a behavioural ALU model
module tb_alu_exec_unit;
  import alu_exec_pkg::*;

  localparam int DEPTH = 2;
`ifdef ALU_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           flush = 1'b0;
  logic           rs_result_en = 1'b0;
  rs_alu_output_t rs_result = '0;
  logic           unit_ready;
  logic           cdb_req;
  logic           cdb_grant = 1'b0;
  cdb_t           cdb_out;

  alu_exec_unit #(.OUT_DEPTH(DEPTH), .ROB_W(ALU_ROB_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .rs_result_en(rs_result_en),
    .rs_result(rs_result), .unit_ready(unit_ready), .cdb_req(cdb_req),
    .cdb_grant(cdb_grant), .cdb_out(cdb_out)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  cdb_t exp_q[$];
  logic [ALU_ROB_W-1:0] tag = '0;
  logic credit = 1'b0;
  logic held_valid = 1'b0;
  cdb_t held = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0]  sh;
    longint unsigned wide;
    sh = b[4:0];
    case (op)
      4'd0: begin wide = longint'(a) + longint'(b); return wide[31:0]; end
      4'd1: return a * (32'd1 << sh);
      4'd2: return a[31] ? ~((~a) >> sh) : (a >> sh);
      4'd3: begin wide = longint'(a) + (64'h1_0000_0000 - longint'(b)); return wide[31:0]; end
      4'd4: return a ^ b;
      4'd5: return 32'(longint'(a) / (longint'(1) << sh));
      4'd6: return a | b;
      4'd7: return a & b;
      4'd8: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      4'd9: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction

  // RS view: unit_ready seen in one cycle permits an issue in the next.
  always @(negedge clk) credit = unit_ready;

  always @(negedge clk) begin
    if (rst_n) begin
      if (held_valid && cdb_req) check("hold_stable", cdb_out, held);
      if (cdb_req && cdb_grant) begin
        if (exp_q.size() == 0) begin
          check("unexpected_cdb", {28'd0, cdb_out}, 64'hDEAD);
        end else begin
          check("cdb_result", cdb_out, exp_q.pop_front());
        end
      end
      held_valid = cdb_req && !cdb_grant && !flush;
      held = cdb_out;
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
    rs_result_en = 1'b1;
    rs_result = '{operation: op, q1_data: a, q2_data: b, rob_dest: tag};
    if (expect_it) exp_q.push_back('{rob_entry: tag, rd_data: ref_alu(op, a, b)});
    tag = tag + 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!credit && g < 100) begin
      tick();
      g++;
    end
    if (!credit) check("credit_wait", credit, 1);
    drive_op(op, a, b, 1'b1);
    tick();
    rs_result_en = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      tick();
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [3:0]  v_op [8] = '{4'd0, 4'd3, 4'd2, 4'd8, 4'd9, 4'd12, 4'd1, 4'd5};
  logic [31:0] v_a  [8] = '{32'h7FFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234, 32'h1, 32'h80000000};
  logic [31:0] v_b  [8] = '{32'h1, 32'h1, 32'd31, 32'h1, 32'h1, 32'h5678, 32'h3F, 32'd4};

  initial begin
    int accepted;
    cdb_t exp_b;
    bit fl;
    logic [31:0] ra, rb;

    repeat (2) tick();
    @(negedge clk);
    check("reset_req", cdb_req, 0);
    check("reset_ready", unit_ready, 1);
    check("reset_out", cdb_out, 0);
    rst_n = 1'b1;
    tick();

    // issue-to-request latency with grant tied high
    cdb_grant = 1'b1;
    tick();
    drive_op(4'd0, 32'd5, 32'd7, 1'b1);
    tick();
    rs_result_en = 1'b0;
    @(negedge clk);
    check("latency_n1_req", cdb_req, BYP);
    tick();
    @(negedge clk);
    check("latency_n2_req", cdb_req, !BYP);
    tick();
    drain();

    for (int i = 0; i < 8; i++) send(v_op[i], v_a[i], v_b[i]);
    drain();

    // backpressure: grant low, RS issues whenever credited
    cdb_grant = 1'b0;
    tag = '0;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      if (credit) begin
        drive_op(4'd4, 32'hA5A5_0000 + 32'(i), 32'h0F0F_0F0F, 1'b1);
        accepted++;
      end else begin
        rs_result_en = 1'b0;
      end
      tick();
    end
    rs_result_en = 1'b0;
    check("bp_accepted", accepted, DEPTH);
    @(negedge clk);
    check("bp_ready_low", unit_ready, 0);
    check("bp_req", cdb_req, 1);
    check("bp_head_tag", cdb_out.rob_entry, 0);
    tick();
    cdb_grant = 1'b1;
    drain();

    // simultaneous push and pop
    cdb_grant = 1'b0;
    send(4'd6, 32'h1111_0000, 32'h0000_2222);
    repeat (3) tick();
    exp_b = '{rob_entry: tag, rd_data: ref_alu(4'd7, 32'hF0F0_FFFF, 32'h0FF0_00F0)};
    send(4'd7, 32'hF0F0_FFFF, 32'h0FF0_00F0);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    @(negedge clk);
    check("pp_req", cdb_req, 1);
    check("pp_head", cdb_out, exp_b);
    tick();
    cdb_grant = 1'b1;
    tick();
    @(negedge clk);
    check("pp_count_one", cdb_req, 0);
    tick();
    drain();

    // flush with an issue in the flush cycle
    cdb_grant = 1'b0;
    send(4'd0, 32'd1, 32'd2);
    send(4'd0, 32'd3, 32'd4);
    drive_op(4'd0, 32'd5, 32'd6, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    rs_result_en = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_req", cdb_req, 0);
    check("flush_ready", unit_ready, 1);
    tick();
    cdb_grant = 1'b1;
    repeat (8) tick();

    // asynchronous reset mid-stream
    cdb_grant = 1'b0;
    send(4'd3, 32'd9, 32'd4);
    send(4'd1, 32'd3, 32'd2);
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("areset_req", cdb_req, 0);
    check("areset_ready", unit_ready, 1);
    check("areset_out", cdb_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cdb_grant = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("post_reset_req", cdb_req, 0);
    tick();

    // randomized traffic with occasional flushes
    for (int i = 0; i < 500; i++) begin
      cdb_grant = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 39) == 0);
      if (credit && $urandom_range(0, 2) != 0) begin
        ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        rb = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        drive_op(4'($urandom_range(0, 15)), ra, rb, !fl);
      end else begin
        rs_result_en = 1'b0;
      end
      flush = fl;
      tick();
      if (fl) begin
        flush = 1'b0;
        exp_q.delete();
      end
    end
    rs_result_en = 1'b0;
    cdb_grant = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
